vend_sequencer: RTL and testbench
=================================

VEND_SEQUENCER -- requirements
Module: vend_sequencer

Interface
REQ-001 SHALL have parameter PRICE, default 3, product price in coin units (1..12).
REQ-002 SHALL have parameter TIMEOUT, default 255, idle cycles in COLLECT before auto-refund (1..255).
REQ-003 SHALL have port clk  input  1  clock, rising edge active.
REQ-004 SHALL have port arstn  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port coin_valid  input  1  coin presented this cycle.
REQ-006 SHALL have port coin_val  input  2  coin value: 01 = 1 unit, 10 = 2 units, 00/11 = invalid.
REQ-007 SHALL have port cancel  input  1  user cancel request, level-sampled.
REQ-008 SHALL have port disp_ack  input  1  dispenser completion acknowledge.
REQ-009 SHALL have port disp_req  output  1  dispense request to dispenser.
REQ-010 SHALL have port chg_pulse  output  1  one-cycle pulse per returned coin unit.
REQ-011 SHALL have port coin_reject  output  1  one-cycle pulse when a presented coin is not accepted.
REQ-012 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-013 SHALL have port credit  output  4  current accumulated credit, registered.

Function
REQ-014 SHALL implement states IDLE, COLLECT, DISPENSE, CHANGE, REFUND in one registered state variable.
REQ-015 SHALL, in IDLE or COLLECT, add coin_val to credit on a cycle with coin_valid high and valid coin_val, with the updated credit visible on the next cycle.
REQ-016 SHALL pulse coin_reject on the cycle after coin_valid with invalid coin_val in any state, or with any coin_val in DISPENSE, CHANGE or REFUND, and leave credit unchanged.
REQ-017 SHALL move IDLE -> COLLECT on the first accepted coin, or directly to DISPENSE if the updated credit is >= PRICE.
REQ-018 SHALL move COLLECT -> DISPENSE on the cycle after the updated credit reaches >= PRICE.
REQ-019 SHALL, when a coin and cancel coincide in COLLECT, accept the coin first and then take the cancel, unless the coin completes the price, in which case DISPENSE wins.
REQ-020 SHALL move COLLECT -> REFUND on cancel high, or after TIMEOUT consecutive cycles without an accepted coin; the timeout counter is 8 bits and clears on every accepted coin.
REQ-021 SHALL hold disp_req high from DISPENSE entry until disp_ack is sampled high, and deassert it on the following cycle, clearing the dispenser wait with no timeout.
REQ-022 SHALL, on disp_ack in DISPENSE, subtract PRICE from credit and then go to CHANGE if the remainder is > 0, otherwise to IDLE.
REQ-023 SHALL ignore cancel in DISPENSE and CHANGE, and ignore disp_ack outside DISPENSE.
REQ-024 SHALL, in CHANGE and REFUND, emit one chg_pulse per cycle and decrement credit by 1 per pulse, then go to IDLE on the cycle credit reaches 0.
REQ-025 SHALL keep credit <= PRICE+1, so no overflow is possible at 4 bits for PRICE <= 12.

Reset
REQ-026 SHALL, on arstn low, immediately force state IDLE, credit 0, timeout counter 0, and disp_req, chg_pulse, coin_reject and busy to 0, including mid-dispense or mid-change; credit in flight is lost.
REQ-027 SHALL leave reset synchronously with the first clk edge after arstn goes high, and accept no coin on that edge.

Configuration
REQ-028 SHALL, with VEND_CHANGE_EN defined, implement CHANGE and REFUND as specified above.
REQ-029 SHALL, without VEND_CHANGE_EN, omit CHANGE and REFUND, tie chg_pulse to 0, clear credit to 0 on disp_ack (forfeiting excess), and clear credit and return to IDLE in one cycle on cancel or timeout.

Structure
REQ-030 SHALL place the state encoding typedef, the coin value constants (COIN_1, COIN_2) and the default PRICE/TIMEOUT constants in the shared package vend_pkg.
REQ-031 SHALL implement the idle timeout as the sub-module vend_timeout (load/clear, enable, expire output).

Verification
REQ-032 SHALL cover PRICE=3 with coins 1, 2 -> disp_req high the cycle after the second coin, ack -> credit 0, IDLE, no chg_pulse.
REQ-033 SHALL cover PRICE=3 with coins 2, 2 -> dispense, ack -> exactly 1 chg_pulse, credit 0, IDLE (with VEND_CHANGE_EN).
REQ-034 SHALL cover coin 2 then cancel -> REFUND, 2 chg_pulses on consecutive cycles, busy low after them.
REQ-035 SHALL cover coin 1 then 255 idle cycles -> REFUND on cycle 255, 1 chg_pulse; a coin at cycle 254 restarts the count.
REQ-036 SHALL cover a coin presented during DISPENSE, and coin_val=11 in IDLE -> coin_reject pulse each time, credit unchanged.
REQ-037 SHALL cover arstn low while disp_req is high -> disp_req, credit and busy are 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/vend_pkg.sv
// vend_pkg -- shared types and constants for the vending sequencer.
//   vend_state_t : sequencer state encoding
//   COIN_1/COIN_2: legal coin_val codes (1 and 2 units)
//   PRICE_DEF / TIMEOUT_DEF : default parameter values
//   coin_units() : coin code to credit units (0 for an illegal code)
package vend_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_COLLECT  = 3'd1,
    ST_DISPENSE = 3'd2,
    ST_CHANGE   = 3'd3,
    ST_REFUND   = 3'd4
  } vend_state_t;

  localparam logic [1:0] COIN_1 = 2'b01;
  localparam logic [1:0] COIN_2 = 2'b10;

  localparam int PRICE_DEF   = 3;
  localparam int TIMEOUT_DEF = 255;

  function automatic logic [3:0] coin_units(input logic [1:0] code);
    if (code == COIN_2)      return 4'd2;
    else if (code == COIN_1) return 4'd1;
    else                     return 4'd0;
  endfunction

endpackage

// File: rtl/vend_if.sv
// vend_if -- user/dispenser-facing signal bundle of the vending sequencer.
//   coin_valid, coin_val[1:0] : coin presented this cycle and its code
//   cancel                    : user cancel request (level)
//   disp_ack                  : dispenser completion acknowledge
//   disp_req                  : dispense request
//   chg_pulse                 : one pulse per returned coin unit
//   coin_reject               : pulse when a presented coin was not taken
//   busy                      : sequencer not idle
//   credit[3:0]               : accumulated credit
// modport master drives the inputs of the sequencer; slave is the sequencer.
interface vend_if;
  logic       coin_valid;
  logic [1:0] coin_val;
  logic       cancel;
  logic       disp_ack;
  logic       disp_req;
  logic       chg_pulse;
  logic       coin_reject;
  logic       busy;
  logic [3:0] credit;

  modport master (
    output coin_valid, coin_val, cancel, disp_ack,
    input  disp_req, chg_pulse, coin_reject, busy, credit
  );

  modport slave (
    input  coin_valid, coin_val, cancel, disp_ack,
    output disp_req, chg_pulse, coin_reject, busy, credit
  );
endinterface

// File: rtl/vend_timeout.sv
// vend_timeout -- idle timer for the COLLECT phase.
//   clk, arstn : clock, async active-low reset
//   clr        : restart the count (accepted coin)
//   en         : count this cycle (collecting, no coin accepted)
//   expire     : high on the TIMEOUT-th consecutive enabled cycle
module vend_timeout #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic arstn,
  input  logic clr,
  input  logic en,
  output logic expire
);

  logic [7:0] cnt;

  // cnt holds the number of enabled cycles already elapsed, so the
  // TIMEOUT-th one is seen while cnt is still TIMEOUT-1.
  assign expire = en && !clr && (cnt == 8'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn)      cnt <= 8'd0;
    else if (clr)    cnt <= 8'd0;
    else if (expire) cnt <= 8'd0;
    else if (en)     cnt <= cnt + 8'd1;
  end

endmodule

// File: rtl/vend_sequencer.sv
// vend_sequencer -- coin collection / dispense / change sequencer.
//   clk   : clock, rising edge
//   arstn : asynchronous active-low reset
//   bus   : vend_if.slave (coin inputs, cancel, dispenser handshake,
//           change pulses, reject pulse, busy, credit)
// Parameters: PRICE (coin units, 1..12), TIMEOUT (idle cycles, 1..255).
// Build option: VEND_CHANGE_EN enables the CHANGE and REFUND states; without
// it excess credit is forfeited on dispense and cancel/timeout simply clear
// the credit.
//
//   state       | meaning
//   ------------+----------------------------------------------
//   ST_IDLE     | no credit, waiting for the first coin
//   ST_COLLECT  | partial credit, waiting for coins/cancel/timeout
//   ST_DISPENSE | disp_req high, waiting for disp_ack
//   ST_CHANGE   | returning credit above PRICE, one unit per cycle
//   ST_REFUND   | returning all credit after cancel/timeout
module vend_sequencer
  import vend_pkg::*;
#(
  parameter int PRICE   = PRICE_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic arstn,
  vend_if.slave bus
);

  localparam logic [3:0] PRICE_U = 4'(PRICE);

  vend_state_t state;
  logic        run;
  logic [3:0]  credit_q;
  logic        disp_req_q, chg_pulse_q, coin_reject_q, busy_q;

  logic [3:0]  units, sum;
  logic        coin_good, coin_ok, tmr_clr, tmr_en, expire;

  always_comb begin
    units     = coin_units(bus.coin_val);
    coin_good = bus.coin_valid && (units != 4'd0);
    coin_ok   = run && coin_good && (state == ST_IDLE || state == ST_COLLECT);
    sum       = credit_q + units;
    tmr_clr   = coin_ok;
    tmr_en    = run && (state == ST_COLLECT) && !coin_ok;
  end

  vend_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk    (clk),
    .arstn  (arstn),
    .clr    (tmr_clr),
    .en     (tmr_en),
    .expire (expire)
  );

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      state         <= ST_IDLE;
      run           <= 1'b0;
      credit_q      <= 4'd0;
      disp_req_q    <= 1'b0;
      chg_pulse_q   <= 1'b0;
      coin_reject_q <= 1'b0;
      busy_q        <= 1'b0;
    end else if (!run) begin
      // first edge after reset release only arms the sequencer
      run <= 1'b1;
    end else begin
      coin_reject_q <= bus.coin_valid && !coin_ok;
      chg_pulse_q   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (coin_ok) begin
            credit_q <= sum;
            busy_q   <= 1'b1;
            if (sum >= PRICE_U) begin
              state      <= ST_DISPENSE;
              disp_req_q <= 1'b1;
            end else begin
              state <= ST_COLLECT;
            end
          end
        end

        ST_COLLECT: begin
          // a price-completing coin beats cancel; otherwise the coin is
          // banked and the cancel/timeout is taken on the same edge
          if (coin_ok && sum >= PRICE_U) begin
            credit_q   <= sum;
            state      <= ST_DISPENSE;
            disp_req_q <= 1'b1;
          end else if (bus.cancel || expire) begin
`ifdef VEND_CHANGE_EN
            credit_q <= coin_ok ? sum : credit_q;
            state    <= ST_REFUND;
`else
            credit_q <= 4'd0;
            state    <= ST_IDLE;
            busy_q   <= 1'b0;
`endif
          end else if (coin_ok) begin
            credit_q <= sum;
          end
        end

        ST_DISPENSE: begin
          if (bus.disp_ack) begin
            disp_req_q <= 1'b0;
`ifdef VEND_CHANGE_EN
            if (credit_q > PRICE_U) begin
              credit_q <= credit_q - PRICE_U;
              state    <= ST_CHANGE;
            end else begin
              credit_q <= 4'd0;
              state    <= ST_IDLE;
              busy_q   <= 1'b0;
            end
`else
            credit_q <= 4'd0;
            state    <= ST_IDLE;
            busy_q   <= 1'b0;
`endif
          end
        end

`ifdef VEND_CHANGE_EN
        ST_CHANGE, ST_REFUND: begin
          chg_pulse_q <= 1'b1;
          credit_q    <= credit_q - 4'd1;
          if (credit_q == 4'd1) begin
            state  <= ST_IDLE;
            busy_q <= 1'b0;
          end
        end
`endif

        default: begin
          state      <= ST_IDLE;
          credit_q   <= 4'd0;
          disp_req_q <= 1'b0;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  assign bus.disp_req    = disp_req_q;
  assign bus.chg_pulse   = chg_pulse_q;
  assign bus.coin_reject = coin_reject_q;
  assign bus.busy        = busy_q;
  assign bus.credit      = credit_q;

endmodule

// File: tb/tb_vend_sequencer.sv
module tb_vend_sequencer;

  localparam int PRICE   = 3;
  localparam int TIMEOUT = 255;
`ifdef VEND_CHANGE_EN
  localparam bit CHG = 1'b1;
`else
  localparam bit CHG = 1'b0;
`endif

  logic clk = 1'b0;
  logic arstn = 1'b0;
  always #5 clk = ~clk;

  vend_if bus ();

  vend_sequencer #(.PRICE(PRICE), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .arstn (arstn),
    .bus   (bus)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // reference model: credit balance plus "what is the machine doing" flags
  int m_cr;
  int m_idle;
  bit m_wait_ack, m_returning, m_collecting, m_skip;
  bit e_req, e_pulse, e_rej, e_busy;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_cr = 0; m_idle = 0;
    m_wait_ack = 0; m_returning = 0; m_collecting = 0;
    e_req = 0; e_pulse = 0; e_rej = 0; e_busy = 0;
  endtask

  task automatic give_back();
    m_collecting = 0;
    if (CHG) m_returning = (m_cr > 0);
    else     m_cr = 0;
  endtask

  task automatic model_step(input bit cv, input logic [1:0] val, input bit can, input bit ack);
    bit legal, was_coll;
    int u;
    if (m_skip) begin
      m_skip = 0; e_rej = 0; e_pulse = 0;
      return;
    end
    u = (val == 2'b01) ? 1 : (val == 2'b10) ? 2 : 0;
    legal = cv && (u != 0);
    e_pulse = 0;
    e_rej = cv && !(legal && !m_wait_ack && !m_returning);
    if (m_returning) begin
      m_cr = m_cr - 1;
      e_pulse = 1;
      if (m_cr == 0) m_returning = 0;
    end else if (m_wait_ack) begin
      if (ack) begin
        m_wait_ack = 0;
        m_cr = CHG ? m_cr - PRICE : 0;
        if (m_cr > 0) m_returning = 1;
      end
    end else begin
      was_coll = m_collecting;
      if (legal) begin
        m_cr = m_cr + u;
        m_idle = 0;
        if (m_cr >= PRICE) begin
          m_wait_ack = 1; m_collecting = 0;
        end else if (was_coll && can) begin
          give_back();
        end else begin
          m_collecting = 1;
        end
      end else if (was_coll) begin
        m_idle++;
        if (can || m_idle == TIMEOUT) give_back();
      end
    end
    e_req  = m_wait_ack;
    e_busy = m_collecting || m_wait_ack || m_returning;
  endtask

  task automatic check_all();
    chk("credit",      {4'b0, bus.credit},      8'(m_cr));
    chk("disp_req",    {7'b0, bus.disp_req},    {7'b0, e_req});
    chk("chg_pulse",   {7'b0, bus.chg_pulse},   {7'b0, e_pulse});
    chk("coin_reject", {7'b0, bus.coin_reject}, {7'b0, e_rej});
    chk("busy",        {7'b0, bus.busy},        {7'b0, e_busy});
  endtask

  task automatic tick(input bit cv, input logic [1:0] val, input bit can, input bit ack);
    bus.coin_valid = cv; bus.coin_val = val; bus.cancel = can; bus.disp_ack = ack;
    @(posedge clk);
    model_step(cv, val, can, ack);
    #1;
    check_all();
  endtask

  task automatic idle(input int n);
    repeat (n) tick(1'b0, 2'b00, 1'b0, 1'b0);
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1;
    arstn = 1'b1;
    m_skip = 1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bus.coin_valid = 0; bus.coin_val = 2'b00; bus.cancel = 0; bus.disp_ack = 0;
    model_reset();
    #3;
    check_all();
    release_reset();
    // coin on the release edge must be ignored
    tick(1'b1, 2'b10, 1'b0, 1'b0);
    idle(2);

    // coins 1, 2 -> dispense, ack -> credit 0, no change
    tick(1'b1, 2'b01, 1'b0, 1'b0);
    tick(1'b1, 2'b10, 1'b0, 1'b0);
    idle(3);
    tick(1'b0, 2'b00, 1'b0, 1'b1);
    idle(3);

    // coins 2, 2 -> dispense; coin during dispense is rejected; ack -> change
    tick(1'b1, 2'b10, 1'b0, 1'b0);
    tick(1'b1, 2'b10, 1'b0, 1'b0);
    tick(1'b1, 2'b01, 1'b1, 1'b0);
    idle(1);
    tick(1'b0, 2'b00, 1'b0, 1'b1);
    idle(4);

    // illegal coin code in idle
    tick(1'b1, 2'b11, 1'b0, 1'b0);
    tick(1'b1, 2'b00, 1'b0, 1'b0);
    idle(2);

    // coin 2 then cancel -> refund
    tick(1'b1, 2'b10, 1'b0, 1'b0);
    tick(1'b0, 2'b00, 1'b1, 1'b0);
    idle(4);

    // coin + cancel together in collect: coin banked, then refunded
    tick(1'b1, 2'b01, 1'b0, 1'b0);
    tick(1'b1, 2'b01, 1'b1, 1'b0);
    idle(4);

    // coin 1 then timeout
    tick(1'b1, 2'b01, 1'b0, 1'b0);
    idle(TIMEOUT + 3);

    // coin on idle cycle 254 restarts the count
    tick(1'b1, 2'b01, 1'b0, 1'b0);
    idle(TIMEOUT - 2);
    tick(1'b1, 2'b01, 1'b0, 1'b0);
    idle(TIMEOUT + 4);

    // reset while disp_req is high takes effect without a clock edge
    tick(1'b1, 2'b10, 1'b0, 1'b0);
    tick(1'b1, 2'b10, 1'b0, 1'b0);
    idle(2);
    #2;
    arstn = 1'b0;
    #1;
    model_reset();
    check_all();
    release_reset();
    idle(2);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      tick(($urandom_range(0, 2) == 0), 2'($urandom_range(0, 3)),
           ($urandom_range(0, 15) == 0), ($urandom_range(0, 3) == 0));
    end
    idle(10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
